// File: rtl/viterbi_k3_stream.sv
// Hard-decision register-exchange Viterbi decoder, rate 1/2, K=3 (g0=7, g1=5), one symbol per cycle.
// Build option: define VITERBI_TAIL_EN for zero-terminated frames (decode always ends in state 0).
module viterbi_k3_stream #(
  parameter int unsigned FRAME_LEN = 7,
  parameter int unsigned MW        = 8
) (
  input  logic                 clk_div2,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [1:0]           s_sym,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [FRAME_LEN-1:0] dec_data,
  output logic [MW-1:0]        dec_metric
);

  localparam int unsigned NS = 4;
  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [MW-1:0] M_SAT = {MW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [NS-1:0][MW-1:0] METRIC_INIT = {M_SAT, M_SAT, M_SAT, MW'(0)};

  if (FRAME_LEN < 3 || FRAME_LEN > 32) begin : g_bad_len
    $error("viterbi_k3_stream: FRAME_LEN must be within 3..32");
  end
  if ($clog2(2 * FRAME_LEN + 1) > MW) begin : g_bad_mw
    $error("viterbi_k3_stream: MW too narrow to hold 2*FRAME_LEN");
  end

  typedef enum logic [1:0] {IDLE, ACS, SEL, OUT} state_t;

  state_t                       state, state_next;
  logic [CW-1:0]                cnt;
  logic [NS-1:0][MW-1:0]        metric, metric_new;
  logic [NS-1:0][FRAME_LEN-1:0] surv, surv_new;
  logic [FRAME_LEN-1:0]         bit_mask;
  logic [FRAME_LEN-1:0]         sel_data;
  logic [MW-1:0]                sel_metric;
  logic                         accept, frame_init, load_out, release_out;

  // Hamming distance between the received symbol and the encoder output for (pred, u).
  function automatic logic [1:0] branch_metric(input logic [1:0] pred, input logic u,
                                               input logic [1:0] sym);
    logic [1:0] exp_sym;
    logic [1:0] diff;
    exp_sym = {u ^ pred[1] ^ pred[0], u ^ pred[0]};
    diff    = sym ^ exp_sym;
    return 2'(diff[1]) + 2'(diff[0]);
  endfunction

  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] m, input logic [1:0] bm);
    logic [MW:0] sum;
    sum = {1'b0, m} + (MW+1)'(bm);
    return sum[MW] ? M_SAT : sum[MW-1:0];
  endfunction

  assign bit_mask = FRAME_LEN'(1) << cnt;

  // Next state {u,a} is reached from {a,0} or {a,1}; ties keep {a,0}.
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic       U  = 1'(g / 2);
    localparam logic [1:0] P0 = 2'((g % 2) * 2);
    localparam logic [1:0] P1 = 2'((g % 2) * 2 + 1);
    logic [MW-1:0] cand0, cand1;
    logic          take1;

    assign cand0         = sat_add(metric[P0], branch_metric(P0, U, s_sym));
    assign cand1         = sat_add(metric[P1], branch_metric(P1, U, s_sym));
    assign take1         = cand1 < cand0;
    assign metric_new[g] = take1 ? cand1 : cand0;
    assign surv_new[g]   = ((take1 ? surv[P1] : surv[P0]) & ~bit_mask) | (U ? bit_mask : '0);
  end

`ifdef VITERBI_TAIL_EN
  // Tail bits drive the encoder back to state 0; their decoded values are known zeros.
  localparam logic [FRAME_LEN-1:0] TAIL_MASK = ~(FRAME_LEN'(3) << (FRAME_LEN - 2));

  assign sel_data   = surv[0] & TAIL_MASK;
  assign sel_metric = metric[0];
`else
  logic [1:0] best;

  always_comb begin
    best = 2'd0;
    for (int i = 1; i < NS; i++) begin
      if (metric[i] < metric[best]) best = 2'(i);
    end
  end

  assign sel_data   = surv[best];
  assign sel_metric = metric[best];
`endif

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    frame_init  = 1'b0;
    load_out    = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        frame_init = 1'b1;
        state_next = ACS;
      end
      ACS: begin
        if (s_valid && s_ready) begin
          accept = 1'b1;
          if (cnt == CNT_LAST) state_next = SEL;
        end
      end
      SEL: begin
        load_out   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (dec_valid && dec_ready) begin
          release_out = 1'b1;
          frame_init  = 1'b1;
          state_next  = ACS;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_div2) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      metric     <= METRIC_INIT;
      surv       <= '0;
      s_ready    <= 1'b0;
      dec_valid  <= 1'b0;
      dec_data   <= '0;
      dec_metric <= '0;
    end else begin
      state   <= state_next;
      s_ready <= (state_next == ACS);
      if (frame_init) begin
        cnt    <= '0;
        metric <= METRIC_INIT;
        surv   <= '0;
      end else if (accept) begin
        cnt    <= cnt + CW'(1);
        metric <= metric_new;
        surv   <= surv_new;
      end
      if (load_out) begin
        dec_valid  <= 1'b1;
        dec_data   <= sel_data;
        dec_metric <= sel_metric;
      end else if (release_out) begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_k3_stream.sv
// Directed bench for viterbi_k3_stream: table of coded frames plus backpressure and mid-frame reset sequences.
module tb_viterbi_k3_stream;

  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned MW        = 8;

  logic                 clk_div2 = 1'b0;
  logic                 rst      = 1'b0;
  logic                 s_valid  = 1'b0;
  logic [1:0]           s_sym    = 2'b00;
  logic                 dec_ready = 1'b0;
  logic                 s_ready;
  logic                 dec_valid;
  logic [FRAME_LEN-1:0] dec_data;
  logic [MW-1:0]        dec_metric;

  int checks   = 0;
  int failures = 0;

  viterbi_k3_stream #(.FRAME_LEN(FRAME_LEN), .MW(MW)) dut (
    .clk_div2  (clk_div2),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sym     (s_sym),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_data  (dec_data),
    .dec_metric(dec_metric)
  );

  always #5 clk_div2 = ~clk_div2;

  // Symbol i of a frame sits at syms[2*i +: 2]; gaps[i] inserts an idle cycle before symbol i.
  typedef struct packed {
    logic [2*FRAME_LEN-1:0] syms;
    logic [FRAME_LEN-1:0]   gaps;
    logic [FRAME_LEN-1:0]   data;
    logic [MW-1:0]          metric;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_sym(input logic [1:0] sym, input logic gap);
    int n;
    if (gap) begin
      s_valid = 1'b0;
      s_sym   = ~sym;
      @(negedge clk_div2);
    end
    s_valid = 1'b1;
    s_sym   = sym;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk_div2);
      n++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
    @(negedge clk_div2);
    s_valid = 1'b0;
    s_sym   = 2'b00;
  endtask

  // Sends one frame and checks latency, payload; releases the output unless hold is set.
  task automatic run_frame(input string tag, input logic [2*FRAME_LEN-1:0] syms,
                           input logic [FRAME_LEN-1:0] gaps, input logic [FRAME_LEN-1:0] exp_data,
                           input logic [MW-1:0] exp_metric, input logic hold);
    for (int i = 0; i < FRAME_LEN; i++) send_sym(syms[2*i +: 2], gaps[i]);
    check({tag, "_sel_valid"}, 32'(dec_valid), 32'd0);
    check({tag, "_sel_ready"}, 32'(s_ready), 32'd0);
    @(negedge clk_div2);
    check({tag, "_valid"}, 32'(dec_valid), 32'd1);
    check({tag, "_data"}, 32'(dec_data), 32'(exp_data));
    check({tag, "_metric"}, 32'(dec_metric), 32'(exp_metric));
    if (!hold) begin
      dec_ready = 1'b1;
      @(negedge clk_div2);
      dec_ready = 1'b0;
      check({tag, "_released"}, 32'(dec_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // info 1,0,1,1,0,0,1 encodes to 11,10,00,01,01,11,11
    vecs[0] = '{14'b00_00_00_00_00_00_00, 7'b0000000, 7'b0000000, 8'd0};
    vecs[1] = '{14'b11_11_01_01_00_10_11, 7'b0000000, 7'b1001101, 8'd0};
    vecs[2] = '{14'b11_11_01_01_00_11_11, 7'b0000000, 7'b1001101, 8'd1};
    vecs[3] = '{14'b11_11_01_01_00_10_11, 7'b0101010, 7'b1001101, 8'd0};
    vecs[4] = '{14'b00_11_01_01_00_10_11, 7'b0000000, 7'b0001101, 8'd0};
    vecs[5] = '{14'b01_00_00_00_00_00_00, 7'b0000000, 7'b0000000, 8'd1};

    rst = 1'b0;
    repeat (3) @(negedge clk_div2);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_data", 32'(dec_data), 32'd0);
    check("rst_dec_metric", 32'(dec_metric), 32'd0);
    rst = 1'b1;
    @(negedge clk_div2);
    check("idle_one_cycle", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].syms, vecs[i].gaps, vecs[i].data,
                vecs[i].metric, 1'b0);
    end

    // Output backpressure with a waiting symbol: nothing consumed, outputs frozen.
    run_frame("bp", vecs[1].syms, '0, 7'b1001101, 8'd0, 1'b1);
    s_valid = 1'b1;
    s_sym   = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_div2);
      check($sformatf("bp_hold%0d", c), 32'({s_ready, dec_valid, dec_data, dec_metric}),
            32'({1'b0, 1'b1, 7'b1001101, 8'd0}));
    end
    dec_ready = 1'b1;
    @(negedge clk_div2);
    dec_ready = 1'b0;
    s_valid   = 1'b0;
    check("bp_released", 32'(dec_valid), 32'd0);
    run_frame("bp_next", vecs[4].syms, '0, 7'b0001101, 8'd0, 1'b0);

    // Reset after 4 symbols must discard the partial frame.
    for (int i = 0; i < 4; i++) send_sym(2'b11, 1'b0);
    rst = 1'b0;
    @(negedge clk_div2);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check("midrst_dec_data", 32'(dec_data), 32'd0);
    check("midrst_dec_metric", 32'(dec_metric), 32'd0);
    rst = 1'b1;
    run_frame("post_rst", vecs[0].syms, '0, 7'b0000000, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
